// File: rtl/raster_addr_gen_pkg.sv
// Shared types and default widths for the raster address generator.
package raster_addr_gen_pkg;

  localparam int ADDR_BITS_DEF = 16;
  localparam int DIM_BITS_DEF  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/raster_dim_counter.sv
// Loadable index counter that wraps to zero when stepped at its maximum.
module raster_dim_counter #(
  parameter int W = 10
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic         step_i,
  input  logic [W-1:0] max_i,
  output logic [W-1:0] idx_o,
  output logic         at_max_o
);

  assign at_max_o = (idx_o == max_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)     idx_o <= '0;
    else if (load_i) idx_o <= '0;
    else if (step_i) idx_o <= at_max_o ? '0 : idx_o + 1'b1;
  end

endmodule

// File: rtl/raster_addr_gen.sv
// Raster-order address sequencer: addr = base + row*stride + col, one beat per handshake.
// Define RASTER_ADDR_GEN_OVF_CHECK_EN to add the sticky ovf_o address-wrap flag.
module raster_addr_gen
  import raster_addr_gen_pkg::*;
#(
  parameter int AddrBits = ADDR_BITS_DEF,
  parameter int DimBits  = DIM_BITS_DEF
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [AddrBits-1:0] base_addr_i,
  input  logic [DimBits-1:0]  cols_i,
  input  logic [DimBits-1:0]  rows_i,
  input  logic [AddrBits-1:0] row_stride_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [AddrBits-1:0] addr_o,
  output logic [DimBits-1:0]  row_o,
  output logic [DimBits-1:0]  col_o,
  output logic                last_o,
  output logic                busy_o,
  output logic                done_o
`ifdef RASTER_ADDR_GEN_OVF_CHECK_EN
  ,
  output logic                ovf_o
`endif
);

  state_e state_q, state_d;

  logic [DimBits-1:0]  cols_m1_q, rows_m1_q;
  logic [AddrBits-1:0] stride_q, row_base_q;
  logic                start_acc, xfer, col_max, row_max, row_adv;

  assign start_acc = (state_q == IDLE) & start_i;
  assign valid_o   = (state_q == RUN);
  assign busy_o    = (state_q != IDLE);
  assign done_o    = (state_q == DONE);
  assign xfer      = valid_o & ready_i;
  assign row_adv   = xfer & col_max & ~row_max;
  assign last_o    = valid_o & col_max & row_max;
  assign addr_o    = row_base_q + AddrBits'(col_o);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = ((cols_i == '0) || (rows_i == '0)) ? DONE : RUN;
      RUN:     if (xfer && col_max && row_max) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cols_m1_q  <= '0;
      rows_m1_q  <= '0;
      stride_q   <= '0;
      row_base_q <= '0;
    end else begin
      state_q <= state_d;
      if (start_acc) begin
        // Zero extents wrap here but are never used: a zero tile skips RUN.
        cols_m1_q  <= cols_i - 1'b1;
        rows_m1_q  <= rows_i - 1'b1;
        stride_q   <= row_stride_i;
        row_base_q <= base_addr_i;
      end else if (row_adv) begin
        row_base_q <= row_base_q + stride_q;
      end
    end
  end

  raster_dim_counter #(.W(DimBits)) u_col (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (start_acc),
    .step_i  (xfer),
    .max_i   (cols_m1_q),
    .idx_o   (col_o),
    .at_max_o(col_max)
  );

  raster_dim_counter #(.W(DimBits)) u_row (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .load_i  (start_acc),
    .step_i  (xfer & col_max),
    .max_i   (rows_m1_q),
    .idx_o   (row_o),
    .at_max_o(row_max)
  );

`ifdef RASTER_ADDR_GEN_OVF_CHECK_EN
  // A wrapped row_base taints every later beat of the tile, so remember it.
  logic                base_wrap_q, ovf_q, beat_ovf;
  logic [AddrBits:0]   beat_sum, base_sum;

  assign beat_sum = {1'b0, row_base_q} + {1'b0, AddrBits'(col_o)};
  assign base_sum = {1'b0, row_base_q} + {1'b0, stride_q};
  assign beat_ovf = valid_o & (base_wrap_q | beat_sum[AddrBits]);
  assign ovf_o    = ovf_q | beat_ovf;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      base_wrap_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else if (start_acc) begin
      base_wrap_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      if (beat_ovf) ovf_q <= 1'b1;
      if (row_adv && base_sum[AddrBits]) base_wrap_q <= 1'b1;
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (rst_ni && beat_ovf && !ovf_q)
      $error("raster_addr_gen: address wrap at row %0d col %0d", row_o, col_o);
  end
`endif
`endif

endmodule

// File: tb/tb_raster_addr_gen.sv
// Directed bench for raster_addr_gen with a queue-based expected-beat model.
module tb_raster_addr_gen;
  localparam int AW = 16;
  localparam int DW = 10;

  logic          clk = 1'b0, rst_ni = 1'b0, start_i = 1'b0, ready_i = 1'b1;
  logic [AW-1:0] base_addr_i = '0, row_stride_i = '0;
  logic [DW-1:0] cols_i = '0, rows_i = '0;
  logic          valid_o, last_o, busy_o, done_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] row_o, col_o;
`ifdef RASTER_ADDR_GEN_OVF_CHECK_EN
  logic          ovf_o;
`endif

  always #5 clk = ~clk;

  raster_addr_gen #(.AddrBits(AW), .DimBits(DW)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i), .base_addr_i(base_addr_i),
    .cols_i(cols_i), .rows_i(rows_i), .row_stride_i(row_stride_i),
    .valid_o(valid_o), .ready_i(ready_i), .addr_o(addr_o), .row_o(row_o),
    .col_o(col_o), .last_o(last_o), .busy_o(busy_o), .done_o(done_o)
`ifdef RASTER_ADDR_GEN_OVF_CHECK_EN
    , .ovf_o(ovf_o)
`endif
  );

  typedef struct {
    logic [AW-1:0] a;
    int            r;
    int            c;
    bit            l;
  } beat_t;

  beat_t    expq[$];
  int       total = 0, bad = 0, done_cnt = 0, rdy_mode = 0, n;
  bit       chk_en = 0;
  bit [3:0] pat = 4'b1001;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp_v);
    end
  endtask

  // Expected beats straight from the addressing rule, nested raster loops.
  task automatic push_tile(input int base, input int cols, input int rows, input int stride);
    beat_t b;
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < cols; c++) begin
        b.a = AW'(base + r * stride + c);
        b.r = r;
        b.c = c;
        b.l = (r == rows - 1) && (c == cols - 1);
        expq.push_back(b);
      end
  endtask

  task automatic set_cfg(input int base, input int cols, input int rows, input int stride);
    base_addr_i  = AW'(base);
    cols_i       = DW'(cols);
    rows_i       = DW'(rows);
    row_stride_i = AW'(stride);
  endtask

  task automatic start_tile(input int base, input int cols, input int rows, input int stride);
    @(posedge clk); #1;
    set_cfg(base, cols, rows, stride);
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    set_cfg(0, 0, 0, 0);
  endtask

  // n = number of negedges after the start edge until done_o is seen.
  task automatic wait_done(output int cnt);
    cnt = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (done_o) begin
        cnt = i;
        break;
      end
    end
    if (cnt == 0) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int k = 0;
    forever begin
      @(posedge clk); #1;
      ready_i = (rdy_mode == 0) ? 1'b1 : pat[k % 4];
      k++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      if (valid_o) begin
        if (expq.size() == 0) chk("extra_beat", 1, 0);
        else begin
          chk("addr", addr_o, expq[0].a);
          chk("row", row_o, expq[0].r);
          chk("col", col_o, expq[0].c);
          chk("last", last_o, expq[0].l);
          chk("busy_run", busy_o, 1);
          if (ready_i) void'(expq.pop_front());
        end
      end else begin
        chk("last_idle", last_o, 0);
      end
      if (done_o) done_cnt++;
    end
  end

  initial begin
    int dc;
    #12;
    chk("rst_valid", valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_last", last_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_row", row_o, 0);
    chk("rst_col", col_o, 0);
    rst_ni = 1'b1;
    chk_en = 1'b1;

    // 3x2 tile, ready held high
    push_tile(16'h100, 3, 2, 16'h10);
    chk("model_a0", expq[0].a, 16'h100);
    chk("model_a3", expq[3].a, 16'h110);
    chk("model_a5", expq[5].a, 16'h112);
    chk("model_l4", expq[4].l, 0);
    chk("model_l5", expq[5].l, 1);
    start_tile(16'h100, 3, 2, 16'h10);
    wait_done(n);
    chk("t1_done_cyc", n, 7);
    chk("t1_drained", expq.size(), 0);
    @(negedge clk);
    chk("t1_busy_after", busy_o, 0);
    chk("t1_done_once", done_o, 0);

    // same tile with stalls
    rdy_mode = 1;
    push_tile(16'h100, 3, 2, 16'h10);
    start_tile(16'h100, 3, 2, 16'h10);
    wait_done(n);
    chk("t2_drained", expq.size(), 0);
    rdy_mode = 0;

    // zero extents: straight to DONE
    start_tile(16'h200, 0, 4, 16'h10);
    wait_done(n);
    chk("t3_cols0_cyc", n, 1);
    chk("t3_cols0_busy", busy_o, 1);
    start_tile(16'h200, 5, 0, 16'h10);
    wait_done(n);
    chk("t3_rows0_cyc", n, 1);

    // start held through RUN with new config
    push_tile(16'h100, 3, 2, 16'h10);
    push_tile(16'h900, 2, 2, 16'h20);
    @(posedge clk); #1;
    set_cfg(16'h100, 3, 2, 16'h10);
    start_i = 1'b1;
    @(posedge clk); #1;
    set_cfg(16'h900, 2, 2, 16'h20);
    wait_done(n);
    chk("t4_a_cyc", n, 7);
    chk("t4_a_only", expq.size(), 4);
    @(posedge clk);
    @(posedge clk); #1;
    start_i = 1'b0;
    wait_done(n);
    chk("t4_b_cyc", n, 5);
    chk("t4_drained", expq.size(), 0);
    repeat (3) begin
      @(negedge clk);
      chk("t4_quiet", valid_o | busy_o, 0);
    end

    // async reset mid-tile
    push_tile(16'h40, 4, 4, 8);
    start_tile(16'h40, 4, 4, 8);
    @(negedge clk);
    @(negedge clk);
    #1 rst_ni = 1'b0;
    #1;
    chk("t5_valid", valid_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_addr", addr_o, 0);
    chk("t5_row", row_o, 0);
    chk("t5_col", col_o, 0);
    expq.delete();
    dc = done_cnt;
    repeat (3) @(negedge clk);
    rst_ni = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_no_done", done_cnt, dc);
    push_tile(16'h300, 2, 2, 16'h100);
    start_tile(16'h300, 2, 2, 16'h100);
    wait_done(n);
    chk("t5_restart_cyc", n, 5);
    chk("t5_drained", expq.size(), 0);

    // 1x1 tile
    push_tile(16'h55, 1, 1, 0);
    start_tile(16'h55, 1, 1, 0);
    wait_done(n);
    chk("t6_cyc", n, 2);

    // address wrap
    push_tile(16'hFFFE, 4, 1, 0);
    chk("model_wrap", expq[2].a, 16'h0000);
    start_tile(16'hFFFE, 4, 1, 0);
    wait_done(n);
    chk("t7_cyc", n, 5);
    chk("t7_drained", expq.size(), 0);
`ifdef RASTER_ADDR_GEN_OVF_CHECK_EN
    chk("t7_ovf_set", ovf_o, 1);
    push_tile(0, 1, 1, 0);
    start_tile(0, 1, 1, 0);
    chk("t7_ovf_clr", ovf_o, 0);
    wait_done(n);
`endif

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
